// File: rtl/tm_lif_scheduler_pkg.sv
// Shared types and constants for the time-multiplexed LIF neuron scheduler.
package tm_lif_pkg;

  localparam int VMEM_W = 10;
  localparam int SYN_W  = 10;

  localparam logic signed [SYN_W-1:0] SYN_MAX = 10'sh1FF;
  localparam logic signed [SYN_W-1:0] SYN_MIN = 10'sh200;

  // Tag entries carry a fixed-width index so the type can live here; the
  // scheduler checks at elaboration that its own index width fits.
  localparam int TAG_IDX_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    DONE
  } sched_state_e;

  typedef struct packed {
    logic                 valid;
    logic [TAG_IDX_W-1:0] idx;
  } tag_t;

  // Signed add clamped to the synaptic-current range.
  function automatic logic signed [SYN_W-1:0] sat10(
    input logic signed [SYN_W-1:0] a,
    input logic signed [SYN_W-1:0] b
  );
    logic signed [SYN_W:0] sum;
    sum = $signed({a[SYN_W-1], a}) + $signed({b[SYN_W-1], b});
    if (sum > $signed({SYN_MAX[SYN_W-1], SYN_MAX})) begin
      return SYN_MAX;
    end else if (sum < $signed({SYN_MIN[SYN_W-1], SYN_MIN})) begin
      return SYN_MIN;
    end else begin
      return sum[SYN_W-1:0];
    end
  endfunction

endpackage

// File: rtl/tm_lif_scheduler_if.sv
// Bus bundle between the scheduler and its environment: synaptic write port,
// LIF datapath link and the spike-index stream.
interface tm_lif_scheduler_if #(
  parameter int IDX_W = 4
);
  import tm_lif_pkg::*;

  logic              syn_wr_valid;
  logic [IDX_W-1:0]  syn_wr_idx;
  logic [SYN_W-1:0]  syn_wr_data;

  logic [VMEM_W-1:0] lif_vmem_o;
  logic [SYN_W-1:0]  lif_syn_o;
  logic [VMEM_W-1:0] lif_vmem_i;
  logic              lif_spike_i;

  logic              spk_valid;
  logic [IDX_W-1:0]  spk_idx;
  logic              spk_ready;

  // Scheduler side.
  modport slave (
    input  syn_wr_valid, syn_wr_idx, syn_wr_data,
    input  lif_vmem_i, lif_spike_i,
    input  spk_ready,
    output lif_vmem_o, lif_syn_o,
    output spk_valid, spk_idx
  );

  // Environment side: synapse source, LIF datapath and spike consumer.
  modport master (
    output syn_wr_valid, syn_wr_idx, syn_wr_data,
    output lif_vmem_i, lif_spike_i,
    output spk_ready,
    input  lif_vmem_o, lif_syn_o,
    input  spk_valid, spk_idx
  );

endinterface

// File: rtl/tm_lif_scheduler_spike_fifo.sv
// Small synchronous FIFO with full/empty flags. No push-to-pop bypass: a word
// pushed into an empty FIFO becomes visible the following cycle.
module spike_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 8
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] pushData_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] popData_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_badDepth
    $error("spike_fifo: DEPTH must be a power of two >= 2");
  end

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wrPtr_q;
  logic [PTR_W-1:0] rdPtr_q;
  logic [CNT_W-1:0] count_q;
  logic             doPush;
  logic             doPop;

  assign empty_o   = (count_q == '0);
  assign full_o    = (count_q == CNT_W'(DEPTH));
  assign doPop     = pop_i && !empty_o;
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign doPush    = push_i && (!full_o || doPop);
  assign popData_o = mem_q[rdPtr_q];

  // Storage array; contents are don't-care while the FIFO is empty.
  always_ff @(posedge clk_i) begin
    if (doPush) begin
      mem_q[wrPtr_q] <= pushData_i;
    end
  end

  // Pointers and occupancy; pointers wrap naturally since DEPTH is 2^n.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (doPush) begin
        wrPtr_q <= wrPtr_q + PTR_W'(1);
      end
      if (doPop) begin
        rdPtr_q <= rdPtr_q + PTR_W'(1);
      end
      if (doPush && !doPop) begin
        count_q <= count_q + CNT_W'(1);
      end else if (doPop && !doPush) begin
        count_q <= count_q - CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/tm_lif_scheduler.sv
// Time-multiplexed neuron-state sequencer: on each tick, streams every
// neuron's membrane voltage and accumulated synaptic current through an
// external LIF pipeline, writes the returned voltage back and queues the
// indices of neurons that spiked.
module tm_lif_scheduler
  import tm_lif_pkg::*;
#(
  parameter int N_NEURONS  = 16,
  parameter int IDX_W      = 4,
  parameter int LIF_LAT    = 3,
  parameter int FIFO_DEPTH = 8
) (
  input  logic               clk_in,
  input  logic               reset,
  input  logic               tick,
  tm_lif_scheduler_if.slave  bus,
  output logic               busy,
  output logic               done,
  output logic               overflow
);

  // A neuron must retire before it is issued again, otherwise the next
  // sweep would read a stale voltage.
  if (N_NEURONS < LIF_LAT + 1) begin : g_badLat
    $error("tm_lif_scheduler: N_NEURONS must be >= LIF_LAT+1");
  end
  if (LIF_LAT < 1) begin : g_badLatMin
    $error("tm_lif_scheduler: LIF_LAT must be >= 1");
  end
  if (IDX_W != $clog2(N_NEURONS) || IDX_W > TAG_IDX_W) begin : g_badIdx
    $error("tm_lif_scheduler: IDX_W must equal clog2(N_NEURONS) and fit a tag");
  end

  sched_state_e             state_q, state_d;
  logic [IDX_W-1:0]         issueIdx_q, issueIdx_d;
  logic [VMEM_W-1:0]        vmemMem_q [N_NEURONS];
  logic signed [SYN_W-1:0]  synAcc_q  [N_NEURONS];
  tag_t                     tagPipe_q [LIF_LAT];
  tag_t                     issueTag;
  tag_t                     retireTag;
  logic [IDX_W-1:0]         retireIdx;
  logic                     issuing;
  logic                     tickAccept;
  logic                     pipeDraining;
  logic                     fifoPush;
  logic                     fifoPop;
  logic                     fifoFull;
  logic                     fifoEmpty;
  logic                     overflow_q;

  assign issueTag.valid = issuing;
  assign issueTag.idx   = TAG_IDX_W'(issueIdx_q);
  assign retireTag      = tagPipe_q[LIF_LAT-1];
  assign retireIdx      = retireTag.idx[IDX_W-1:0];

  // Tags still in flight after this cycle; the tail stage retires now, so
  // leaving it out lets DONE follow the final writeback directly.
  always_comb begin
    pipeDraining = 1'b0;
    for (int i = 0; i < LIF_LAT - 1; i++) begin
      pipeDraining = pipeDraining | tagPipe_q[i].valid;
    end
  end

  // Sweep sequencing: next state, issue counter and status outputs.
  always_comb begin
    state_d    = state_q;
    issueIdx_d = issueIdx_q;
    issuing    = 1'b0;
    tickAccept = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (tick) begin
          tickAccept = 1'b1;
          issueIdx_d = '0;
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        issuing    = 1'b1;
        issueIdx_d = issueIdx_q + IDX_W'(1);
        if (issueIdx_q == IDX_W'(N_NEURONS - 1)) begin
          issueIdx_d = '0;
          state_d    = DRAIN;
        end
      end
      DRAIN: begin
        if (!pipeDraining) begin
          state_d = DONE;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and issue-counter registers.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      state_q    <= IDLE;
      issueIdx_q <= '0;
    end else begin
      state_q    <= state_d;
      issueIdx_q <= issueIdx_d;
    end
  end

  // Present the neuron being issued to the LIF datapath; idle bus reads zero.
  always_comb begin
    bus.lif_vmem_o = '0;
    bus.lif_syn_o  = '0;
    if (issuing) begin
      bus.lif_vmem_o = vmemMem_q[issueIdx_q];
      bus.lif_syn_o  = synAcc_q[issueIdx_q];
    end
  end

  // Tag pipe tracks which neuron each LIF result belongs to.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      for (int i = 0; i < LIF_LAT; i++) begin
        tagPipe_q[i] <= '0;
      end
    end else begin
      tagPipe_q[0] <= issueTag;
      for (int i = 1; i < LIF_LAT; i++) begin
        tagPipe_q[i] <= tagPipe_q[i-1];
      end
    end
  end

  // Write each returning membrane voltage back to its neuron.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      for (int i = 0; i < N_NEURONS; i++) begin
        vmemMem_q[i] <= '0;
      end
    end else if (retireTag.valid) begin
      for (int i = 0; i < N_NEURONS; i++) begin
        if (retireTag.idx == TAG_IDX_W'(i)) begin
          vmemMem_q[i] <= bus.lif_vmem_i;
        end
      end
    end
  end

  // Accumulate synaptic input; issuing a neuron hands its sum to the LIF and
  // restarts it, and a write in that same cycle seeds the fresh sum.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      for (int i = 0; i < N_NEURONS; i++) begin
        synAcc_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_NEURONS; i++) begin
        if (bus.syn_wr_valid && (bus.syn_wr_idx == IDX_W'(i))) begin
          if (issuing && (issueIdx_q == IDX_W'(i))) begin
            synAcc_q[i] <= sat10('0, bus.syn_wr_data);
          end else begin
            synAcc_q[i] <= sat10(synAcc_q[i], bus.syn_wr_data);
          end
        end else if (issuing && (issueIdx_q == IDX_W'(i))) begin
          synAcc_q[i] <= '0;
        end
      end
    end
  end

  assign fifoPush      = retireTag.valid && bus.lif_spike_i;
  assign fifoPop       = bus.spk_valid && bus.spk_ready;
  assign bus.spk_valid = !fifoEmpty;

  spike_fifo #(
    .WIDTH (IDX_W),
    .DEPTH (FIFO_DEPTH)
  ) u_spikeFifo (
    .clk_i      (clk_in),
    .reset_i    (reset),
    .push_i     (fifoPush),
    .pushData_i (retireIdx),
    .pop_i      (fifoPop),
    .popData_o  (bus.spk_idx),
    .full_o     (fifoFull),
    .empty_o    (fifoEmpty)
  );

  // Sticky drop flag, rearmed by the next accepted tick.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      overflow_q <= 1'b0;
    end else if (fifoPush && fifoFull && !fifoPop) begin
      overflow_q <= 1'b1;
    end else if (tickAccept) begin
      overflow_q <= 1'b0;
    end
  end

  assign overflow = overflow_q;

endmodule

// File: tb/tb_tm_lif_scheduler.sv
// Directed bench for tm_lif_scheduler with a behavioural 3-cycle LIF stub.
module tb_tm_lif_scheduler;
  import tm_lif_pkg::*;

  localparam int N    = 16;
  localparam int IDXW = 4;
  localparam int LAT  = 3;
  localparam int NREC = 24;

  localparam int M_PASS = 0;
  localparam int M_ACC  = 1;
  localparam int M_LIF  = 2;
  localparam int M_SPK  = 3;

  logic clk = 1'b0;
  logic reset;
  logic tick;
  logic busy;
  logic done;
  logic overflow;

  int errors = 0;
  int checks = 0;
  int lifMode = M_PASS;

  int recVmem  [NREC];
  int recSyn   [NREC];
  int recBusy  [NREC];
  int recDone  [NREC];
  int recValid [NREC];
  int recIdx   [NREC];
  int recOvf   [NREC];

  typedef struct {
    int idx;
    int d1;
    int d2;
    int expSyn;
  } synVec_t;

  synVec_t vecs [7];

  tm_lif_scheduler_if #(.IDX_W(IDXW)) bus ();

  tm_lif_scheduler #(
    .N_NEURONS  (N),
    .IDX_W      (IDXW),
    .LIF_LAT    (LAT),
    .FIFO_DEPTH (8)
  ) dut (
    .clk_in   (clk),
    .reset    (reset),
    .tick     (tick),
    .bus      (bus),
    .busy     (busy),
    .done     (done),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  // Behavioural LIF: result for an input sampled in cycle c is visible in c+3.
  function automatic logic [10:0] lifModel(input int mode, input logic [9:0] v,
                                           input logic [9:0] s);
    int sum;
    logic [9:0] vo;
    logic spk;
    vo  = v;
    spk = 1'b0;
    case (mode)
      M_ACC: vo = v + s;
      M_LIF: begin
        if (v[9]) begin
          vo = '0;
        end else begin
          sum = int'(v[8:0]) + int'($signed(s));
          if (sum >= 100) begin
            vo  = 10'h200;
            spk = 1'b1;
          end else if (sum < 0) begin
            vo = '0;
          end else begin
            vo = {1'b0, sum[8:0]};
          end
        end
      end
      M_SPK: spk = 1'b1;
      default: ;
    endcase
    return {spk, vo};
  endfunction

  logic [9:0]  stubV [LAT];
  logic [9:0]  stubS [LAT];
  logic [10:0] lifResult;

  // LIF stub pipeline registers.
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < LAT; i++) begin
        stubV[i] <= '0;
        stubS[i] <= '0;
      end
    end else begin
      stubV[0] <= bus.lif_vmem_o;
      stubS[0] <= bus.lif_syn_o;
      for (int i = 1; i < LAT; i++) begin
        stubV[i] <= stubV[i-1];
        stubS[i] <= stubS[i-1];
      end
    end
  end

  assign lifResult       = lifModel(lifMode, stubV[LAT-1], stubS[LAT-1]);
  assign bus.lif_vmem_i  = lifResult[9:0];
  assign bus.lif_spike_i = lifResult[10];

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic toNextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    reset            = 1'b1;
    tick             = 1'b0;
    bus.syn_wr_valid = 1'b0;
    bus.syn_wr_idx   = '0;
    bus.syn_wr_data  = '0;
    bus.spk_ready    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // One-cycle synaptic write.
  task automatic applyStimulus(input int idx, input int data);
    bus.syn_wr_valid = 1'b1;
    bus.syn_wr_idx   = IDXW'(idx);
    bus.syn_wr_data  = 10'(data);
    toNextCycle();
    bus.syn_wr_valid = 1'b0;
  endtask

  // Tick in cycle 0, then record outputs for cycles 0..NREC-1 while optionally
  // injecting a syn write, a reset, an extra tick and consumer readiness.
  task automatic runSweep(input int mode, input int readyFrom, input int wrCycle,
                          input int wrIdx, input int wrData, input int rstCycle,
                          input int extraTick);
    lifMode = mode;
    for (int c = 0; c < NREC; c++) begin
      tick             = (c == 0) || (c == extraTick);
      bus.spk_ready    = (c >= readyFrom);
      bus.syn_wr_valid = (c == wrCycle);
      bus.syn_wr_idx   = IDXW'(wrIdx);
      bus.syn_wr_data  = 10'(wrData);
      reset            = (c == rstCycle);
      @(negedge clk);
      recVmem[c]  = int'(bus.lif_vmem_o);
      recSyn[c]   = int'($signed(bus.lif_syn_o));
      recBusy[c]  = int'(busy);
      recDone[c]  = int'(done);
      recValid[c] = int'(bus.spk_valid);
      recIdx[c]   = int'(bus.spk_idx);
      recOvf[c]   = int'(overflow);
      toNextCycle();
    end
    tick             = 1'b0;
    bus.syn_wr_valid = 1'b0;
    reset            = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int cnt;

    vecs[0] = '{5,   300,  300,  511};
    vecs[1] = '{1,  -300, -300, -512};
    vecs[2] = '{7,   100,  -30,   70};
    vecs[3] = '{0,   511,    0,  511};
    vecs[4] = '{15, -512,   -1, -512};
    vecs[5] = '{9,   200, -250,  -50};
    vecs[6] = '{12,    0,    0,    0};

    doReset();
    @(negedge clk);
    checkOutput("reset busy", int'(busy), 0);
    checkOutput("reset done", int'(done), 0);
    checkOutput("reset overflow", int'(overflow), 0);
    checkOutput("reset spk_valid", int'(bus.spk_valid), 0);
    checkOutput("reset lif_vmem", int'(bus.lif_vmem_o), 0);
    checkOutput("reset lif_syn", int'(bus.lif_syn_o), 0);
    toNextCycle();

    // Plain sweep, extra tick mid-sweep must be ignored.
    $display("[TB] sweep timing and idle stub");
    runSweep(M_PASS, 99, -1, 0, 0, -1, 10);
    checkOutput("t1 busy cycle0", recBusy[0], 0);
    cnt = 0;
    for (int c = 1; c <= 20; c++) cnt += recBusy[c];
    checkOutput("t1 busy cycles 1..20", cnt, 20);
    checkOutput("t1 busy cycle21", recBusy[21], 0);
    checkOutput("t1 busy cycle23", recBusy[23], 0);
    checkOutput("t1 done cycle19", recDone[19], 0);
    checkOutput("t1 done cycle20", recDone[20], 1);
    cnt = 0;
    for (int c = 0; c < NREC; c++) cnt += recDone[c];
    checkOutput("t1 done pulses", cnt, 1);
    cnt = 0;
    for (int c = 1; c <= 16; c++) cnt += (recVmem[c] != 0) ? 1 : 0;
    checkOutput("t1 nonzero vmem", cnt, 0);
    cnt = 0;
    for (int c = 0; c < NREC; c++) cnt += recValid[c];
    checkOutput("t1 spk_valid cycles", cnt, 0);

    // Table of accumulator writes including both saturation limits.
    $display("[TB] syn accumulation table");
    for (int i = 0; i < 7; i++) begin
      applyStimulus(vecs[i].idx, vecs[i].d1);
      applyStimulus(vecs[i].idx, vecs[i].d2);
    end
    runSweep(M_ACC, 99, -1, 0, 0, -1, -1);
    for (int i = 0; i < 7; i++) begin
      checkOutput($sformatf("tab syn[%0d]", vecs[i].idx), recSyn[vecs[i].idx + 1],
                  vecs[i].expSyn);
    end
    runSweep(M_PASS, 99, -1, 0, 0, -1, -1);
    for (int i = 0; i < 7; i++) begin
      checkOutput($sformatf("tab vmem[%0d]", vecs[i].idx), recVmem[vecs[i].idx + 1],
                  vecs[i].expSyn & 1023);
      checkOutput($sformatf("tab cleared syn[%0d]", vecs[i].idx),
                  recSyn[vecs[i].idx + 1], 0);
    end

    // Write landing on the neuron being issued; tick during DONE ignored.
    $display("[TB] write collides with issue");
    applyStimulus(3, 7);
    runSweep(M_PASS, 99, 4, 3, 20, -1, 20);
    checkOutput("t3 issued syn[3]", recSyn[4], 7);
    checkOutput("t3 busy after done tick", recBusy[21], 0);
    checkOutput("t3 busy later", recBusy[23], 0);
    runSweep(M_PASS, 99, -1, 0, 0, -1, -1);
    checkOutput("t3 next syn[3]", recSyn[4], 20);

    // Threshold LIF: neuron 2 fires once.
    $display("[TB] spike through LIF stub");
    doReset();
    applyStimulus(2, 150);
    runSweep(M_LIF, 99, -1, 0, 0, -1, -1);
    checkOutput("t4 spk_valid cycle6", recValid[6], 0);
    checkOutput("t4 spk_valid cycle7", recValid[7], 1);
    checkOutput("t4 spk_idx cycle7", recIdx[7], 2);
    checkOutput("t4 overflow", recOvf[23], 0);
    bus.spk_ready = 1'b1;
    toNextCycle();
    bus.spk_ready = 1'b0;
    @(negedge clk);
    checkOutput("t4 spk_valid after pop", int'(bus.spk_valid), 0);
    toNextCycle();
    runSweep(M_PASS, 99, -1, 0, 0, -1, -1);
    checkOutput("t4 vmem[2] refractory", recVmem[3], 512);

    // FIFO overflow, then full FIFO with simultaneous pop/push.
    $display("[TB] fifo overflow and drain");
    doReset();
    runSweep(M_SPK, 99, -1, 0, 0, -1, -1);
    checkOutput("t5 spk_valid cycle4", recValid[4], 0);
    checkOutput("t5 spk_valid cycle5", recValid[5], 1);
    checkOutput("t5 overflow cycle12", recOvf[12], 0);
    checkOutput("t5 overflow cycle13", recOvf[13], 1);
    checkOutput("t5 overflow sticky", recOvf[23], 1);
    runSweep(M_SPK, 4, -1, 0, 0, -1, -1);
    checkOutput("t5 overflow at tick", recOvf[0], 1);
    checkOutput("t5 overflow cleared", recOvf[1], 0);
    for (int c = 4; c < NREC; c++) begin
      checkOutput($sformatf("t5 pop idx cycle%0d", c), recIdx[c],
                  (c < 20) ? ((c - 4) % 8) : (c - 12));
    end
    cnt = 0;
    for (int c = 4; c < NREC; c++) cnt += recValid[c];
    checkOutput("t5 valid during drain", cnt, NREC - 4);
    checkOutput("t5 no overflow on full+pop", recOvf[23], 0);
    for (int i = 12; i < 16; i++) begin
      @(negedge clk);
      checkOutput($sformatf("t5 tail idx%0d", i), int'(bus.spk_idx), i);
      toNextCycle();
    end
    @(negedge clk);
    checkOutput("t5 fifo empty", int'(bus.spk_valid), 0);
    bus.spk_ready = 1'b0;
    toNextCycle();

    // Reset in the middle of a sweep.
    $display("[TB] reset mid-sweep");
    doReset();
    applyStimulus(2, 40);
    applyStimulus(12, 60);
    runSweep(M_ACC, 99, -1, 0, 0, -1, -1);
    applyStimulus(14, 33);
    runSweep(M_ACC, 99, -1, 0, 0, 10, -1);
    checkOutput("t6 vmem[2] before reset", recVmem[3], 40);
    checkOutput("t6 busy cycle10", recBusy[10], 1);
    checkOutput("t6 busy cycle11", recBusy[11], 0);
    cnt = 0;
    for (int c = 0; c < NREC; c++) cnt += recDone[c];
    checkOutput("t6 no done", cnt, 0);
    runSweep(M_PASS, 99, -1, 0, 0, -1, -1);
    checkOutput("t6 vmem[2] cleared", recVmem[3], 0);
    checkOutput("t6 vmem[12] cleared", recVmem[13], 0);
    checkOutput("t6 syn[14] cleared", recSyn[15], 0);
    checkOutput("t6 done after reset", recDone[20], 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tm_lif_scheduler.md
Name: tm_lif_scheduler

Overview:
Time-multiplexed neuron-state sequencer wrapped around the 3-stage LIF datapath. Holds membrane and synaptic-current state for N_NEURONS neurons. On each tick it streams every neuron's vmem and accumulated syn into the LIF pipeline and writes the returned vmem back. Spike flags from the LIF are collected into a spike-index FIFO with a valid/ready interface.

Parameters:
N_NEURONS, 16, neurons served per tick; must be >= LIF_LAT+1
IDX_W, 4, neuron index width; equals clog2(N_NEURONS)
LIF_LAT, 3, LIF datapath latency in cycles
FIFO_DEPTH, 8, spike FIFO entries; power of two

Ports:
clk_in  in  1  clock
reset  in  1  synchronous, active-high reset
tick  in  1  one-cycle pulse that starts a sweep; honoured only in IDLE
syn_wr_valid  in  1  accumulate syn_wr_data into neuron syn_wr_idx
syn_wr_idx  in  IDX_W  target neuron
syn_wr_data  in  10  signed synaptic increment
lif_vmem_o  out  10  to LIF vmem_i (bit9 = refractory/sign flag, treated as opaque)
lif_syn_o  out  10  to LIF syn_i, signed
lif_vmem_i  in  10  from LIF vmem_o
lif_spike_i  in  1  from LIF LIF_spike
spk_valid  out  1  FIFO non-empty
spk_idx  out  IDX_W  index of the spiking neuron at FIFO head
spk_ready  in  1  consumer pop
busy  out  1  state != IDLE
done  out  1  one-cycle pulse when the sweep completes
overflow  out  1  sticky: a spike was dropped because the FIFO was full

Behaviour:
- Reset: vmem_mem and syn_acc all 0; FIFO empty; tag pipe cleared; state IDLE. Outputs lif_* = 0, spk_valid = 0, busy = 0, done = 0, overflow = 0.
- FSM states are IDLE, ISSUE, DRAIN, DONE.
  - IDLE -> ISSUE on tick.
  - ISSUE issues idx 0..N_NEURONS-1, one per cycle. After idx N_NEURONS-1 it goes to DRAIN.
  - DRAIN -> DONE when the tag pipe holds no valid entries.
  - DONE asserts done for 1 cycle, then returns to IDLE.
  - tick outside IDLE is ignored.
- Issue: in cycle k+1 after tick is sampled (cycle 0), lif_vmem_o = vmem_mem[k] and lif_syn_o = syn_acc[k], both combinational from state. syn_acc[k] is cleared at the end of that cycle. Outside ISSUE, lif_* = 0.
- Tag pipe: LIF_LAT-deep shift register of {valid, idx}, loaded at issue. The result for idx k is present in cycle k+1+LIF_LAT. At the end of that cycle:
  - vmem_mem[k] <= lif_vmem_i;
  - if lif_spike_i, push k into the FIFO.
- Latency: done is high in cycle N_NEURONS+LIF_LAT+1 after tick is sampled, which is cycle 20 for the defaults.
- Syn accumulation: syn_acc[i] <= sat10(syn_acc[i] + syn_wr_data), where sat10 is signed saturation to [-512, 511]. This is allowed in every state.
  - If a write targets the neuron being issued in the same cycle, the issued value is the old accumulator. The accumulator becomes sat10(0 + syn_wr_data), so no increment is lost.
- The same-neuron RAW hazard cannot occur because N_NEURONS > LIF_LAT. Elaboration fails otherwise.
- FIFO:
  - Pop when spk_valid && spk_ready.
  - A push while full is allowed only if a pop happens in the same cycle. Otherwise the spike is dropped and overflow is set.
  - overflow clears only on reset or an accepted tick.
  - Push and pop on an empty FIFO: the push is stored and spk_valid rises in the next cycle; no bypass.
- Reset mid-sweep: everything returns to the reset state immediately. In-flight LIF results are ignored, because the tag valids are cleared.

Decomposition:
- Package tm_lif_pkg holds:
  - VMEM_W = 10, SYN_W = 10;
  - SYN_MAX = 511, SYN_MIN = -512;
  - the FSM state enum;
  - typedef of the tag pipe entry.
- Sub-module spike_fifo (parameterised width/depth, synchronous reset, valid/ready, full/empty) holds the FIFO. Everything else lives in tm_lif_scheduler.

Test Plan:
1. Reset then tick with no syn writes, LIF stub returns vmem unchanged with no spikes -> lif_vmem_o = 0 for idx 0..15 in cycles 1..16; done high in cycle 20; busy high in cycles 1..20; spk_valid stays 0.
2. syn_wr to idx 5 with +300 twice -> accumulator saturates at 511; at the next tick lif_syn_o = 511 in cycle 6; syn_acc[5] reads 0 afterwards.
3. syn_wr to idx 3 with +20 in the cycle idx 3 is issued, which held 7 -> lif_syn_o = 7; at the next tick lif_syn_o for idx 3 = 20.
4. Real LIF attached (Vth = 100, Vrst = 0, charge = 256) with syn_acc[2] = 150 -> spike; spk_idx = 2 appears, and vmem_mem[2] = 0x200 (bit 9 set, 0 Vrst magnitude) after the sweep.
5. spk_ready = 0, all 16 neurons spike -> 8 entries stored, overflow = 1. The next tick clears overflow, and the FIFO drains idx 0..7 in order.
6. reset asserted in cycle 10 of a sweep -> next cycle busy = 0, vmem_mem unchanged for idx < 6 written earlier … all cleared to 0. A second tick is ignored while busy.
